// File: rtl/io_timer_intc.sv
// io_timer_intc -- memory-mapped countdown timer with a single interrupt line.
//
// Register map (word-aligned, Address[1:0] ignored):
//   0x000 CTRL     bit0 EN, bit1 AUTO (reload on expiry)
//   0x004 PERIOD   reload value
//   0x008 COUNT    current count (read-only)
//   0x00C STATUS   bit0 PEND, bit1 OVF (write-1-to-clear)
//   0x010 PRESCALE 8-bit tick divider (only with IO_TIMER_PRESCALE_EN)
//
// Optional feature macro: IO_TIMER_PRESCALE_EN (prescaler register and divider).
//
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous active-high reset
//   io_cs    I/O chip select
//   io_rd    I/O read strobe
//   io_wr    I/O write strobe
//   Address  12-bit byte address
//   IO_in    32-bit write data
//   IO_out   32-bit read data, combinational, high-Z when not reading
//   intr     interrupt request (registered PEND)
//   int_ack  interrupt acknowledge, clears PEND
module io_timer_intc #(
  parameter logic [31:0] RESET_PERIOD = 32'd1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_cs,
  input  logic        io_rd,
  input  logic        io_wr,
  input  logic [11:0] Address,
  input  logic [31:0] IO_in,
  output logic [31:0] IO_out,
  output logic        intr,
  input  logic        int_ack
);

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 12;
  localparam int unsigned IW = AW - 2;
  localparam int unsigned PW = 8;

  localparam logic [IW-1:0] IDX_CTRL     = IW'(0);
  localparam logic [IW-1:0] IDX_PERIOD   = IW'(1);
  localparam logic [IW-1:0] IDX_COUNT    = IW'(2);
  localparam logic [IW-1:0] IDX_STATUS   = IW'(3);
`ifdef IO_TIMER_PRESCALE_EN
  localparam logic [IW-1:0] IDX_PRESCALE = IW'(4);
`endif

  logic          en_q,     en_d;
  logic          auto_q,   auto_d;
  logic [DW-1:0] period_q, period_d;
  logic [DW-1:0] count_q,  count_d;
  logic          pend_q,   pend_d;
  logic          ovf_q,    ovf_d;
`ifdef IO_TIMER_PRESCALE_EN
  logic [PW-1:0] prescale_q, prescale_d;
  logic [PW-1:0] div_q,      div_d;
`endif

  logic [IW-1:0] idx_c;
  logic          wr_c;
  logic          wr_ctrl_c;
  logic          wr_period_c;
  logic          wr_status_c;
  logic          w1c_pend_c;
  logic          tick_c;
  logic          expire_c;
  logic          addr_unused_c;
  logic [DW-1:0] rdata_c;

  // Address decode on word index; byte-lane bits are don't-care.
  assign idx_c         = Address[AW-1:2];
  assign addr_unused_c = ^Address[1:0];
  assign wr_c          = io_cs & io_wr;
  assign wr_ctrl_c     = wr_c & (idx_c == IDX_CTRL);
  assign wr_period_c   = wr_c & (idx_c == IDX_PERIOD);
  assign wr_status_c   = wr_c & (idx_c == IDX_STATUS);
  assign w1c_pend_c    = wr_status_c & IO_in[0];

  // Tick source: divider when prescaling is built in, else every cycle.
`ifdef IO_TIMER_PRESCALE_EN
  assign tick_c = (div_q >= prescale_q);
`else
  assign tick_c = 1'b1;
`endif

  assign expire_c = tick_c & en_q & (count_q == '0);

  // Next-state logic for all timer and status registers.
  always_comb begin
    en_d     = en_q;
    auto_d   = auto_q;
    period_d = period_q;
    count_d  = count_q;
    pend_d   = pend_q;
    ovf_d    = ovf_q;
`ifdef IO_TIMER_PRESCALE_EN
    prescale_d = prescale_q;
    div_d      = div_q;
`endif

    if (en_q && tick_c) begin
      if (count_q != '0) begin
        count_d = count_q - DW'(1);
      end else if (auto_q) begin
        count_d = period_q;
      end else begin
        en_d = 1'b0;
      end
    end

    // A CTRL write wins over the countdown; disabling freezes COUNT as-is.
    if (wr_ctrl_c) begin
      auto_d = IO_in[1];
      if (IO_in[0] && (period_q != '0)) begin
        en_d    = 1'b1;
        count_d = period_q;
      end else begin
        en_d    = 1'b0;
        count_d = count_q;
      end
    end

    if (wr_period_c) begin
      period_d = IO_in;
    end

    if (wr_status_c) begin
      if (IO_in[0]) pend_d = 1'b0;
      if (IO_in[1]) ovf_d  = 1'b0;
    end

    if (int_ack) begin
      pend_d = 1'b0;
    end

    // Expiry sets PEND with priority; overflow only if the prior request
    // is still unserviced (not being acked or cleared on this same edge).
    if (expire_c) begin
      pend_d = 1'b1;
      if (pend_q && !int_ack && !w1c_pend_c) begin
        ovf_d = 1'b1;
      end
    end

`ifdef IO_TIMER_PRESCALE_EN
    if (wr_c && (idx_c == IDX_PRESCALE)) begin
      prescale_d = IO_in[PW-1:0];
    end
    // Divider restarts when the timer is armed from the disabled state.
    if (wr_ctrl_c && IO_in[0] && (period_q != '0) && !en_q) begin
      div_d = '0;
    end else if (en_q) begin
      div_d = tick_c ? '0 : div_q + PW'(1);
    end
`endif
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_q     <= 1'b0;
      auto_q   <= 1'b0;
      period_q <= RESET_PERIOD;
      count_q  <= '0;
      pend_q   <= 1'b0;
      ovf_q    <= 1'b0;
`ifdef IO_TIMER_PRESCALE_EN
      prescale_q <= '0;
      div_q      <= '0;
`endif
    end else begin
      en_q     <= en_d;
      auto_q   <= auto_d;
      period_q <= period_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
      ovf_q    <= ovf_d;
`ifdef IO_TIMER_PRESCALE_EN
      prescale_q <= prescale_d;
      div_q      <= div_d;
`endif
    end
  end

  assign intr = pend_q;

  // Read mux; unmapped words read as zero.
  always_comb begin
    rdata_c = '0;
    case (idx_c)
      IDX_CTRL:     rdata_c = {30'd0, auto_q, en_q};
      IDX_PERIOD:   rdata_c = period_q;
      IDX_COUNT:    rdata_c = count_q;
      IDX_STATUS:   rdata_c = {30'd0, ovf_q, pend_q};
`ifdef IO_TIMER_PRESCALE_EN
      IDX_PRESCALE: rdata_c = {24'd0, prescale_q};
`endif
      default:      rdata_c = '0;
    endcase
  end

  assign IO_out = (io_cs && io_rd) ? rdata_c : 32'hzzzz_zzzz;

endmodule
